// File: rtl/lfsr_stream_checker.sv
// lfsr_stream_checker
//   Receive-side monitor for a 20-bit LFSR generator that emits two feedback
//   bits per step. Rebuilds the generator register from the incoming stream
//   (SEEK), confirms the prediction over a run of good beats (VERIFY), then
//   free-runs its own copy and counts mismatches against the stream (LOCKED).
//
// Ports
//   clk        in   1      system clock, posedge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      in_bits carries a beat this cycle
//   in_bits    in   2      received feedback pair {fd[1], fd[0]}
//   clear_cnt  in   1      synchronous clear of err_cnt
//   locked     out  1      state == LOCKED
//   err_pulse  out  1      one-cycle pulse after a mismatching LOCKED beat
//   err_cnt    out  ERR_W  saturating count of LOCKED mismatches
//   stuck_zero out  1      sticky: register all-zero when a fill completed
//   state      out  2      0 SEEK, 1 VERIFY, 2 LOCKED
module lfsr_stream_checker #(
   parameter int TA0    = 13,
   parameter int TB0    = 2,
   parameter int TA1    = 9,
   parameter int TB1    = 3,
   parameter int LOCK_N = 16,
   parameter int WIN    = 16,
   parameter int LOSE_N = 4,
   parameter int ERR_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [1:0]       in_bits,
   input  logic             clear_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_cnt,
   output logic             stuck_zero,
   output logic [1:0]       state
);

   localparam int GOOD_W = $clog2(LOCK_N + 1);
   localparam int WIN_W  = (WIN > 1) ? $clog2(WIN) : 1;
   localparam int BAD_W  = $clog2(LOSE_N + 1);

   typedef enum logic [1:0] {
      ST_SEEK   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [19:0]        sreg_q, sreg_d;
   logic [3:0]         fill_q, fill_d;
   logic [GOOD_W-1:0]  good_q, good_d, good_inc;
   logic [WIN_W-1:0]   win_q, win_d;
   logic [BAD_W-1:0]   bad_q, bad_d, bad_inc;
   logic [ERR_W-1:0]   cnt_q, cnt_d;
   logic               pulse_q, pulse_d;
   logic               stuck_q, stuck_d;
   logic               mism;
   logic [1:0]         pred;
   logic [19:0]        shifted;

   // The two oldest bits never reach a tap; they only age out of the register.
   logic               unused_low;
   assign unused_low = &{1'b0, sreg_q[1:0]};

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + ERR_W'(1);
   endfunction

   assign pred     = {sreg_q[TA1] ^ sreg_q[TB1], sreg_q[TA0] ^ sreg_q[TB0]};
   assign shifted  = {in_bits, sreg_q[19:2]};
   assign good_inc = good_q + GOOD_W'(1);

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      fill_d  = fill_q;
      good_d  = good_q;
      win_d   = win_q;
      bad_d   = bad_q;
      stuck_d = stuck_q;
      cnt_d   = cnt_q;
      mism    = 1'b0;
      bad_inc = bad_q;
      if (in_valid) begin
         case (state_q)
            ST_SEEK: begin
               sreg_d = shifted;
               if (fill_q == 4'd9) begin
                  fill_d = 4'd0;
                  // An all-zero fill cannot seed a useful prediction.
                  if (shifted == 20'd0) begin
                     stuck_d = 1'b1;
                  end else begin
                     state_d = ST_VERIFY;
                     good_d  = '0;
                  end
               end else begin
                  fill_d = fill_q + 4'd1;
               end
            end
            ST_VERIFY: begin
               // Keep resynchronising from the stream while verifying.
               sreg_d = shifted;
               if (in_bits == pred) begin
                  if (good_inc == GOOD_W'(LOCK_N)) begin
                     state_d = ST_LOCKED;
                     good_d  = '0;
                     win_d   = '0;
                     bad_d   = '0;
                  end else begin
                     good_d = good_inc;
                  end
               end else begin
                  good_d = '0;
               end
            end
            ST_LOCKED: begin
               // Flywheel on our own prediction so received errors never enter.
               sreg_d  = {pred, sreg_q[19:2]};
               mism    = (in_bits != pred);
               bad_inc = bad_q + BAD_W'(mism);
               if (bad_inc == BAD_W'(LOSE_N)) begin
                  state_d = ST_SEEK;
                  fill_d  = 4'd0;
               end else if (win_q == WIN_W'(WIN - 1)) begin
                  win_d = '0;
                  bad_d = '0;
               end else begin
                  win_d = win_q + WIN_W'(1);
                  bad_d = bad_inc;
               end
            end
            default: state_d = ST_SEEK;
         endcase
      end
      pulse_d = mism;
      if (clear_cnt) begin
         cnt_d = {{(ERR_W-1){1'b0}}, mism};
      end else if (mism) begin
         cnt_d = sat_inc(cnt_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_SEEK;
         sreg_q  <= '0;
         fill_q  <= '0;
         good_q  <= '0;
         win_q   <= '0;
         bad_q   <= '0;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
         stuck_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         fill_q  <= fill_d;
         good_q  <= good_d;
         win_q   <= win_d;
         bad_q   <= bad_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         stuck_q <= stuck_d;
      end
   end

   assign locked     = (state_q == ST_LOCKED);
   assign err_pulse  = pulse_q;
   assign err_cnt    = cnt_q;
   assign stuck_zero = stuck_q;
   assign state      = state_q;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench for lfsr_stream_checker: drives a reference generator stream
// (default taps) with injected bit flips, gaps, resets and clears.
module tb_lfsr_stream_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [1:0]  in_bits = 2'b00;
   logic        clear_cnt = 1'b0;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_cnt;
   logic        stuck_zero;
   logic [1:0]  state;

   int checks = 0;
   int failures = 0;
   logic [19:0] g;
   int vcount;
   logic pulse_seen;

   lfsr_stream_checker dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_bits   (in_bits),
      .clear_cnt (clear_cnt),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_cnt   (err_cnt),
      .stuck_zero(stuck_zero),
      .state     (state)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] fd_of(input logic [19:0] s);
      return {s[9] ^ s[3], s[13] ^ s[2]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle; a valid beat carries the generator feedback XOR flip.
   task automatic beat(input logic v, input logic [1:0] flip, input logic clr);
      @(negedge clk);
      in_valid  = v;
      clear_cnt = clr;
      if (v) begin
         in_bits = fd_of(g) ^ flip;
         g = {fd_of(g), g[19:2]};
      end else begin
         in_bits = 2'($urandom);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_bits   = 2'b11;
      clear_cnt = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_state"}, 32'(state), 32'd0);
      chk({tag, "_locked"}, 32'(locked), 32'd0);
      chk({tag, "_pulse"}, 32'(err_pulse), 32'd0);
      chk({tag, "_cnt"}, 32'(err_cnt), 32'd0);
      chk({tag, "_stuck"}, 32'(stuck_zero), 32'd0);
   endtask

   initial begin
      do_reset();
      chk_reset_outputs("reset");

      // Clean stream from seed FFFFF: SEEK 10 beats, VERIFY 16, lock after 26.
      g = 20'hFFFFF;
      pulse_seen = 1'b0;
      for (int i = 1; i <= 1000; i++) begin
         beat(1'b1, 2'b00, 1'b0);
         pulse_seen = pulse_seen | err_pulse;
         if (i == 9)  chk("seek_b9", 32'(state), 32'd0);
         if (i == 10) chk("verify_b10", 32'(state), 32'd1);
         if (i == 25) chk("nolock_b25", 32'(locked), 32'd0);
         if (i == 26) chk("lock_b26", 32'(locked), 32'd1);
      end
      chk("clean_cnt", 32'(err_cnt), 32'd0);
      chk("clean_locked", 32'(locked), 32'd1);
      chk("clean_nopulse", 32'(pulse_seen), 32'd0);

      // Beat 1001: single bit0 flip.
      beat(1'b1, 2'b01, 1'b0);
      chk("flip_pulse", 32'(err_pulse), 32'd1);
      chk("flip_cnt", 32'(err_cnt), 32'd1);
      chk("flip_locked", 32'(locked), 32'd1);
      beat(1'b0, 2'b00, 1'b0);
      chk("idle_pulse_drop", 32'(err_pulse), 32'd0);
      pulse_seen = 1'b0;
      for (int i = 1002; i <= 1017; i++) begin
         beat(1'b1, 2'b00, 1'b0);
         pulse_seen = pulse_seen | err_pulse;
      end
      chk("after_flip_clean", 32'(pulse_seen), 32'd0);
      chk("after_flip_cnt", 32'(err_cnt), 32'd1);
      beat(1'b1, 2'b00, 1'b1);  // beat 1018 with clear
      chk("clear_cnt", 32'(err_cnt), 32'd0);

      // Beats 1019..1022 start a window: 4 bad beats lose lock.
      beat(1'b1, 2'b01, 1'b0);
      beat(1'b1, 2'b10, 1'b0);
      beat(1'b1, 2'b11, 1'b0);
      chk("bad3_locked", 32'(locked), 32'd1);
      chk("bad3_cnt", 32'(err_cnt), 32'd3);
      beat(1'b1, 2'b01, 1'b0);
      chk("bad4_locked", 32'(locked), 32'd0);
      chk("bad4_state", 32'(state), 32'd0);
      chk("bad4_cnt", 32'(err_cnt), 32'd4);

      // Relock 26 clean beats later (1023..1048).
      for (int i = 1023; i <= 1048; i++) begin
         beat(1'b1, 2'b00, 1'b0);
         if (i == 1032) chk("relock_verify", 32'(state), 32'd1);
         if (i == 1047) chk("relock_b25", 32'(locked), 32'd0);
      end
      chk("relock_b26", 32'(locked), 32'd1);
      chk("relock_cnt_kept", 32'(err_cnt), 32'd4);

      // Lock window starts at 1049; 3 errors in each of two windows.
      beat(1'b1, 2'b00, 1'b1);
      for (int i = 1050; i <= 1080; i++) begin
         if (i == 1050 || i == 1052 || i == 1054 || i == 1066 || i == 1068 || i == 1070)
            beat(1'b1, 2'b01, 1'b0);
         else
            beat(1'b1, 2'b00, 1'b0);
         if (i == 1064) chk("win1_cnt", 32'(err_cnt), 32'd3);
      end
      chk("win2_locked", 32'(locked), 32'd1);
      chk("win2_cnt", 32'(err_cnt), 32'd6);

      // Clear coincident with an error.
      beat(1'b1, 2'b10, 1'b1);
      chk("clr_err_cnt", 32'(err_cnt), 32'd1);
      chk("clr_err_pulse", 32'(err_pulse), 32'd1);

      // Reset while locked.
      do_reset();
      chk_reset_outputs("rst_locked");

      // Gappy clean stream: locks after the 26th valid beat.
      g = 20'hFFFFF;
      vcount = 0;
      for (int i = 0; i < 400; i++) begin
         logic v;
         v = 1'($urandom_range(0, 1));
         beat(v, 2'b00, 1'b0);
         if (v) begin
            vcount++;
            if (vcount == 25) chk("gap_b25", 32'(locked), 32'd0);
            if (vcount == 26) begin
               chk("gap_b26", 32'(locked), 32'd1);
               break;
            end
         end
      end
      chk("gap_reached", 32'(vcount), 32'd26);

      // All-zero stream: sticky flag, never leaves SEEK.
      do_reset();
      g = 20'd0;
      for (int i = 1; i <= 40; i++) begin
         beat(1'b1, 2'b00, 1'b0);
         chk("zero_state", 32'(state), 32'd0);
         if (i == 9)  chk("zero_b9", 32'(stuck_zero), 32'd0);
         if (i == 10) chk("zero_b10", 32'(stuck_zero), 32'd1);
      end
      chk("zero_b40", 32'(stuck_zero), 32'd1);
      do_reset();
      chk("zero_rst", 32'(stuck_zero), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
